// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
interface imem_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC ownership, multi-cycle imem handshake, branch redirect,
// hazard freeze and the IF/ID pipeline register.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_address,
   imem_if.master      imem,
   output logic [31:0] PC_out,
   output logic [31:0] Instruction_out,
   output logic        valid_out
);

   localparam logic [1:0] FETCH   = 2'd0;
   localparam logic [1:0] DISCARD = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   localparam ifid_t BUBBLE = '{pc: 32'h0, instr: 32'h0, valid: 1'b0};

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic [31:0] hold_buf;
   logic [31:0] pc_next;
   ifid_t       ifid;

   assign pc_next        = pc + 32'(PC_STEP);
   // HOLD is the only state without an outstanding request; DISCARD keeps the
   // stale address on the bus until its ack, so pc is not moved until then.
   assign imem.imem_req  = (state != HOLD);
   assign imem.imem_addr = pc;

   assign PC_out          = ifid.pc;
   assign Instruction_out = ifid.instr;
   assign valid_out       = ifid.valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         pend_pc  <= 32'h0;
         hold_buf <= 32'h0;
         ifid     <= BUBBLE;
      end else begin
         case (state)
            FETCH: begin
               if (imem.imem_ack) begin
                  if (branch_taken) begin
                     pc   <= branch_address;
                     ifid <= BUBBLE;
                  end else if (freeze) begin
                     hold_buf <= imem.imem_rdata;
                     state    <= HOLD;
                  end else begin
                     ifid <= '{pc: pc_next, instr: imem.imem_rdata, valid: 1'b1};
                     pc   <= pc_next;
                  end
               end else if (branch_taken) begin
                  pend_pc <= branch_address;
                  ifid    <= BUBBLE;
                  state   <= DISCARD;
               end else if (!freeze) begin
                  ifid <= BUBBLE;
               end
            end
            DISCARD: begin
               ifid <= BUBBLE;
               if (branch_taken)
                  pend_pc <= branch_address;
               if (imem.imem_ack) begin
                  pc    <= branch_taken ? branch_address : pend_pc;
                  state <= FETCH;
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  pc    <= branch_address;
                  ifid  <= BUBBLE;
                  state <= FETCH;
               end else if (!freeze) begin
                  ifid  <= '{pc: pc_next, instr: hold_buf, valid: 1'b1};
                  pc    <= pc_next;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: hand-computed expectations checked with immediate assertions.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_address = 32'h0;
   logic [31:0] PC_out, Instruction_out;
   logic        valid_out;
   int          errors = 0;
   int          checks = 0;

   imem_if mem ();

   if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_address(branch_address), .imem(mem.master),
      .PC_out(PC_out), .Instruction_out(Instruction_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] p, input logic [31:0] i,
                           input logic v);
      chk({tag, ".pc"}, PC_out, p);
      chk({tag, ".instr"}, Instruction_out, i);
      chk({tag, ".valid"}, 32'(valid_out), 32'(v));
   endtask

   task automatic set_mem(input logic ack, input logic [31:0] rd);
      mem.imem_ack   = ack;
      mem.imem_rdata = rd;
   endtask

   initial begin
      set_mem(1'b0, 32'h0);
      step();
      step();
      chk_ifid("reset", 32'h0, 32'h0, 1'b0);
      chk("reset.req", 32'(mem.imem_req), 32'h1);
      chk("reset.addr", mem.imem_addr, 32'h0);
      rst = 1'b0;

      // 1-cycle memory, back-to-back issue
      set_mem(1'b1, 32'h100);
      step();
      chk_ifid("b2b0", 32'h4, 32'h100, 1'b1);
      chk("b2b0.addr", mem.imem_addr, 32'h4);
      set_mem(1'b1, 32'h104);
      step();
      chk_ifid("b2b1", 32'h8, 32'h104, 1'b1);
      chk("b2b1.addr", mem.imem_addr, 32'h8);

      // freeze as addr 8 is acked: word buffered, IF/ID held, request dropped
      freeze = 1'b1;
      set_mem(1'b1, 32'h108);
      step();
      set_mem(1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         chk_ifid("frz", 32'h8, 32'h104, 1'b1);
         chk("frz.req", 32'(mem.imem_req), 32'h0);
         step();
      end
      chk_ifid("frz3", 32'h8, 32'h104, 1'b1);
      chk("frz3.req", 32'(mem.imem_req), 32'h0);
      freeze = 1'b0;
      step();
      chk_ifid("unfrz", 32'hC, 32'h108, 1'b1);
      chk("unfrz.req", 32'(mem.imem_req), 32'h1);
      chk("unfrz.addr", mem.imem_addr, 32'hC);

      // slow memory: three wait cycles per fetch
      for (int k = 0; k < 3; k++) begin
         step();
         chk("slow.valid", 32'(valid_out), 32'h0);
         chk("slow.addr", mem.imem_addr, 32'hC);
      end
      set_mem(1'b1, 32'h10C);
      step();
      chk_ifid("slow", 32'h10, 32'h10C, 1'b1);
      chk("slow.next", mem.imem_addr, 32'h10);

      // branch while fetch of 0x10 is outstanding
      set_mem(1'b0, 32'h0);
      branch_taken   = 1'b1;
      branch_address = 32'h40;
      step();
      branch_taken = 1'b0;
      chk_ifid("disc0", 32'h0, 32'h0, 1'b0);
      chk("disc0.addr", mem.imem_addr, 32'h10);
      chk("disc0.req", 32'(mem.imem_req), 32'h1);
      step();
      chk("disc1.valid", 32'(valid_out), 32'h0);
      chk("disc1.addr", mem.imem_addr, 32'h10);
      set_mem(1'b1, 32'hDEAD_BEEF);
      step();
      chk_ifid("disc2", 32'h0, 32'h0, 1'b0);
      chk("disc2.addr", mem.imem_addr, 32'h40);

      // branch+freeze in HOLD discards the buffered word
      freeze = 1'b1;
      set_mem(1'b1, 32'h140);
      step();
      chk("hold.req", 32'(mem.imem_req), 32'h0);
      set_mem(1'b0, 32'h0);
      branch_taken   = 1'b1;
      branch_address = 32'h80;
      step();
      branch_taken = 1'b0;
      freeze       = 1'b0;
      chk_ifid("hbr", 32'h0, 32'h0, 1'b0);
      chk("hbr.addr", mem.imem_addr, 32'h80);
      chk("hbr.req", 32'(mem.imem_req), 32'h1);
      set_mem(1'b1, 32'h180);
      step();
      chk_ifid("hbr2", 32'h84, 32'h180, 1'b1);

      // acked branch to the top of the address space, then wrap
      branch_taken   = 1'b1;
      branch_address = 32'hFFFF_FFFC;
      set_mem(1'b1, 32'hBAD);
      step();
      branch_taken = 1'b0;
      chk_ifid("wrap0", 32'h0, 32'h0, 1'b0);
      chk("wrap0.addr", mem.imem_addr, 32'hFFFF_FFFC);
      set_mem(1'b1, 32'h77);
      step();
      chk_ifid("wrap1", 32'h0, 32'h77, 1'b1);
      chk("wrap1.addr", mem.imem_addr, 32'h0);

      // async reset in the middle of DISCARD
      set_mem(1'b1, 32'h55);
      step();
      chk_ifid("pre", 32'h4, 32'h55, 1'b1);
      set_mem(1'b0, 32'h0);
      branch_taken   = 1'b1;
      branch_address = 32'h200;
      step();
      branch_taken = 1'b0;
      chk("rdisc.addr", mem.imem_addr, 32'h4);
      #2;
      rst = 1'b1;
      #1;
      chk_ifid("arst", 32'h0, 32'h0, 1'b0);
      chk("arst.addr", mem.imem_addr, 32'h0);
      step();
      rst = 1'b0;
      set_mem(1'b1, 32'h100);
      step();
      chk_ifid("rstart", 32'h4, 32'h100, 1'b1);
      chk("rstart.addr", mem.imem_addr, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
